multitrack_music_memory: RTL and testbench
==========================================

// Module: multitrack_music_memory
// PURPOSE
//  Parametrised successor to the single-song memory unit: stores NUM_TRACKS independent note
//  sequences in one synchronous RAM and streams the selected track to the playback path.
//  Sits between the keyboard/record path (writer) and the autoplay/learning/game engines (reader).
//  Adds per-track length bookkeeping, full/overflow flags, end-of-track status and read gating.
// PARAMETERS
//  DATA_WIDTH   8    bits per stored note word
//  DEPTH        256  words per track (power of 2); ADDR_W = $clog2(DEPTH)
//  NUM_TRACKS   4    number of tracks (power of 2); TRK_W = $clog2(NUM_TRACKS), minimum 1
//  STATE_WIDTH  2    width of current_state; AUTOPLAY=2'b00, LEARNING=2'b01, GAME=2'b10, IDLE=2'b11
// PORTS
//  clk            in   1             system clock, all logic on rising edge
//  rst_n          in   1             asynchronous active-low reset
//  current_state  in   STATE_WIDTH   top-level mode
//  track_sel      in   TRK_W         track addressed by both read and write
//  write_en       in   1             append data_in to selected track
//  write_clr      in   1             clear selected track (length := 0)
//  data_in        in   DATA_WIDTH    note word to store
//  read_en        in   1             request next word of selected track
//  read_rst       in   1             rewind read pointer to 0
//  data_out       out  DATA_WIDTH    read word, valid while output_ready=1
//  output_ready   out  1             one-cycle pulse: data_out valid
//  end_of_track   out  1             level: read pointer == length of selected track
//  duration       out  ADDR_W+1      stored length (words) of selected track
//  full           out  1             level: selected track length == DEPTH
//  write_ovf      out  1             one-cycle pulse: write_en rejected because full
// BEHAVIOUR
//  - Reset: all track lengths 0, read pointer 0, data_out 0, output_ready 0, write_ovf 0.
//    RAM contents not reset. Reset mid-stream aborts any pending read; no output_ready follows.
//  - RAM address = {track_sel, ptr}; one write port, one synchronous read port.
//  - Write: write_en && !full -> RAM[{trk,len}] <= data_in, len[trk] += 1 next edge.
//    write_en && full -> no write, write_ovf=1 next cycle. Writes allowed in every state.
//  - write_clr: len[trk] <= 0, read pointer <= 0; has priority over write_en same cycle.
//  - Read gating: read_active = state in {AUTOPLAY, LEARNING, GAME}. When !read_active:
//    read pointer held at 0, read_en ignored, data_out forced 0, output_ready 0.
//  - Effective rewind = read_rst | !read_active | track_sel changed since last cycle;
//    rewind sets read pointer 0 and wins over read_en same cycle (read_en dropped).
//  - Read: read_en && read_active && !end_of_track && !write_en -> issue RAM read at ptr,
//    ptr += 1; data_out registered, output_ready=1 exactly 1 cycle later (latency 1).
//  - read_en with write_en same cycle: write wins, read_en dropped (requester retries).
//  - read_en at end_of_track: no read, no output_ready (see LOOP_PLAY_EN).
//  - data_out holds last value between pulses while read_active.
//  - Combinational outputs: end_of_track, duration, full derive from selected track registers.
//  - Empty track: duration=0, end_of_track=1 immediately.
//  - Throughput: one word per cycle with read_en held high.
// CONFIGURATION
//  LOOP_PLAY_EN defined: read_en at end_of_track with duration>0 wraps ptr to 0 and reads word 0
//    in that cycle (output_ready next cycle); end_of_track still reflects ptr==length between reads.
//  LOOP_PLAY_EN undefined: playback stops at end_of_track as described above.
// TESTING
//  1 Reset, state=AUTOPLAY, trk0 -> duration=0, end_of_track=1, full=0, output_ready=0.
//  2 Write 0x11,0x22,0x33 to trk1, then 3 read_en cycles -> data_out 0x11,0x22,0x33,
//    each 1 cycle after request; duration=3; 4th read_en -> no output_ready, end_of_track=1.
//  3 DEPTH=4: write 5 words to trk2 -> full=1 after 4th, write_ovf pulse on 5th, duration=4.
//  4 Mid-read switch state to IDLE then back to GAME -> data_out=0 in IDLE, next read returns word 0.
//  5 Same-cycle read_en+write_en on trk1 -> no output_ready, length+1; read_rst+read_en -> ptr=0, no read.
//  6 LOOP_PLAY_EN, trk1 length 3, 5 read_en cycles -> 0x11,0x22,0x33,0x11,0x22.

Source files
------------

// File: rtl/multitrack_music_memory.sv
// Multi-track note memory: NUM_TRACKS sequences in one RAM, streamed to the playback path.
// Optional macro LOOP_PLAY_EN makes a read at end of track wrap back to word 0.
module multitrack_music_memory #(
    parameter  int DATA_WIDTH  = 8,
    parameter  int DEPTH       = 256,
    parameter  int NUM_TRACKS  = 4,
    parameter  int STATE_WIDTH = 2,
    localparam int ADDR_W      = $clog2(DEPTH),
    localparam int TRK_W       = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [STATE_WIDTH-1:0] current_state,
    input  logic [TRK_W-1:0]       track_sel,
    input  logic                   write_en,
    input  logic                   write_clr,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   read_en,
    input  logic                   read_rst,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   output_ready,
    output logic                   end_of_track,
    output logic [ADDR_W:0]        duration,
    output logic                   full,
    output logic                   write_ovf
);

    localparam int                     NT      = 1 << TRK_W;
    localparam logic [STATE_WIDTH-1:0] ST_IDLE = STATE_WIDTH'(2'b11);
    localparam logic [ADDR_W:0]        LEN_MAX = (ADDR_W + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [NT * DEPTH];

    logic [ADDR_W:0]       len_q [NT];
    logic [ADDR_W:0]       len_d [NT];
    logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
    logic [TRK_W-1:0]      trk_prev_q, trk_prev_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  output_ready_q, output_ready_d;
    logic                  write_ovf_q, write_ovf_d;

    logic [ADDR_W:0]       sel_len_s;
    logic                  full_s, eot_s, read_active_s, rewind_s, wr_s, rd_go_s;
    logic [ADDR_W-1:0]     rd_addr_s;

    // Next-state logic for lengths, read pointer and the registered read port.
    always_comb begin
        len_d          = len_q;
        rd_ptr_d       = rd_ptr_q;
        trk_prev_d     = track_sel;
        rd_go_s        = 1'b0;
        rd_addr_s      = rd_ptr_q[ADDR_W-1:0];
        sel_len_s      = len_q[track_sel];
        full_s         = (sel_len_s == LEN_MAX);
        eot_s          = (rd_ptr_q == sel_len_s);
        read_active_s  = (current_state != ST_IDLE);
        // Clearing a track also invalidates the read position, so it rewinds too.
        rewind_s       = read_rst | ~read_active_s | (track_sel != trk_prev_q) | write_clr;
        wr_s           = write_en & ~write_clr & ~full_s;
        write_ovf_d    = write_en & ~write_clr & full_s;

        if (write_clr) begin
            len_d[track_sel] = '0;
        end else if (wr_s) begin
            len_d[track_sel] = sel_len_s + (ADDR_W + 1)'(1);
        end else begin
            len_d[track_sel] = sel_len_s;
        end

        if (rewind_s) begin
            rd_ptr_d = '0;
        end else if (read_en && !write_en) begin
            if (!eot_s) begin
                rd_go_s  = 1'b1;
                rd_ptr_d = rd_ptr_q + (ADDR_W + 1)'(1);
            end else begin
`ifdef LOOP_PLAY_EN
                if (sel_len_s != '0) begin
                    rd_go_s   = 1'b1;
                    rd_addr_s = '0;
                    rd_ptr_d  = (ADDR_W + 1)'(1);
                end else begin
                    rd_go_s = 1'b0;
                end
`else
                rd_go_s = 1'b0;
`endif
            end
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        output_ready_d = rd_go_s;
        if (rd_go_s) begin
            data_out_d = mem[{track_sel, rd_addr_s}];
        end else if (!read_active_s) begin
            data_out_d = '0;
        end else begin
            data_out_d = data_out_q;
        end
    end

    // RAM write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem[{track_sel, sel_len_s[ADDR_W-1:0]}] <= data_in;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NT; i++) begin
                len_q[i] <= '0;
            end
            rd_ptr_q       <= '0;
            trk_prev_q     <= '0;
            data_out_q     <= '0;
            output_ready_q <= 1'b0;
            write_ovf_q    <= 1'b0;
        end else begin
            len_q          <= len_d;
            rd_ptr_q       <= rd_ptr_d;
            trk_prev_q     <= trk_prev_d;
            data_out_q     <= data_out_d;
            output_ready_q <= output_ready_d;
            write_ovf_q    <= write_ovf_d;
        end
    end

    assign data_out     = data_out_q;
    assign output_ready = output_ready_q;
    assign write_ovf    = write_ovf_q;
    assign end_of_track = eot_s;
    assign duration     = sel_len_s;
    assign full         = full_s;

endmodule

// File: tb/tb_multitrack_music_memory.sv
// Bench for multitrack_music_memory: directed scenarios then random traffic vs. a track-array model.
module tb_multitrack_music_memory;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int NT    = 4;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    current_state;
    logic [1:0]    track_sel;
    logic          write_en, write_clr, read_en, read_rst;
    logic [DW-1:0] data_in, data_out;
    logic          output_ready, end_of_track, full, write_ovf;
    logic [AW:0]   duration;

    multitrack_music_memory #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_TRACKS(NT), .STATE_WIDTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .current_state(current_state), .track_sel(track_sel),
        .write_en(write_en), .write_clr(write_clr), .data_in(data_in),
        .read_en(read_en), .read_rst(read_rst), .data_out(data_out),
        .output_ready(output_ready), .end_of_track(end_of_track), .duration(duration),
        .full(full), .write_ovf(write_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each track is an array of words plus a length.
    logic [DW-1:0] m_data [NT][DEPTH];
    int            m_len [NT];
    int            m_ptr, m_prev;
    logic [DW-1:0] m_dout;
    logic          m_ordy, m_ovf;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NT; i++) m_len[i] = 0;
        m_ptr  = 0;
        m_prev = 0;
        m_dout = '0;
        m_ordy = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic check_levels();
        check_eq("duration", 32'(duration), 32'(m_len[track_sel]));
        check_eq("full", 32'(full), 32'(m_len[track_sel] == DEPTH));
        check_eq("end_of_track", 32'(end_of_track), 32'(m_ptr == m_len[track_sel]));
    endtask

    task automatic step(input logic [1:0] st, input logic [1:0] trk, input logic we,
                        input logic wc, input logic [DW-1:0] din, input logic re, input logic rr);
        bit active, rewind;
        int t, old_len;
        current_state = st; track_sel = trk; write_en = we; write_clr = wc;
        data_in = din; read_en = re; read_rst = rr;
        t       = int'(trk);
        old_len = m_len[t];
        active  = (st != 2'b11);
        rewind  = rr || !active || (t != m_prev) || wc;
        m_ovf   = we && !wc && (old_len == DEPTH);
        m_ordy  = 1'b0;
        if (wc) m_len[t] = 0;
        else if (we && old_len < DEPTH) begin
            m_data[t][old_len] = din;
            m_len[t]++;
        end
        if (rewind) m_ptr = 0;
        else if (re && !we) begin
            if (m_ptr < old_len) begin
                m_dout = m_data[t][m_ptr];
                m_ordy = 1'b1;
                m_ptr++;
            end
`ifdef LOOP_PLAY_EN
            else if (old_len > 0) begin
                m_dout = m_data[t][0];
                m_ordy = 1'b1;
                m_ptr  = 1;
            end
`endif
        end
        if (!active) m_dout = '0;
        m_prev = t;
        @(posedge clk);
        #1;
        check_eq("output_ready", 32'(output_ready), 32'(m_ordy));
        if (m_ordy || !active) check_eq("data_out", 32'(data_out), 32'(m_dout));
        check_eq("write_ovf", 32'(write_ovf), 32'(m_ovf));
        check_levels();
    endtask

    initial begin
        logic [DW-1:0] words [3];
        logic [1:0]    cur_trk;
        logic [1:0]    st;
        words = '{8'h11, 8'h22, 8'h33};
        rst_n = 1'b0;
        current_state = 2'b00; track_sel = 2'd0; write_en = 1'b0; write_clr = 1'b0;
        data_in = '0; read_en = 1'b0; read_rst = 1'b0;
        model_reset();
        #22;
        rst_n = 1'b1;

        // Reset state on track 0 in AUTOPLAY.
        check_eq("rst_duration", 32'(duration), 32'd0);
        check_eq("rst_eot", 32'(end_of_track), 32'd1);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_ordy", 32'(output_ready), 32'd0);
        check_eq("rst_dout", 32'(data_out), 32'd0);

        // Three words into track 1, then read them back.
        for (int i = 0; i < 3; i++) step(2'b00, 2'd1, 1'b1, 1'b0, words[i], 1'b0, 1'b0);
        check_eq("t2_duration", 32'(duration), 32'd3);
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 2'd1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            check_eq("t2_rd_ordy", 32'(output_ready), 32'd1);
            check_eq("t2_rd_data", 32'(data_out), 32'(words[i]));
        end
        check_eq("t2_eot", 32'(end_of_track), 32'd1);
        step(2'b00, 2'd1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
`ifndef LOOP_PLAY_EN
        check_eq("t2_eot_no_ordy", 32'(output_ready), 32'd0);
        check_eq("t2_eot_hold", 32'(end_of_track), 32'd1);
`else
        check_eq("t6_wrap_data", 32'(data_out), 32'h11);
`endif

        // Fill track 2 past capacity.
        for (int i = 0; i <= DEPTH; i++) begin
            step(2'b01, 2'd2, 1'b1, 1'b0, 8'(8'hA0 + i), 1'b0, 1'b0);
            if (i == DEPTH - 1) check_eq("t3_full", 32'(full), 32'd1);
            if (i == DEPTH - 1) check_eq("t3_no_ovf_yet", 32'(write_ovf), 32'd0);
        end
        check_eq("t3_ovf", 32'(write_ovf), 32'd1);
        check_eq("t3_duration", 32'(duration), 32'(DEPTH));
        step(2'b01, 2'd2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("t3_ovf_pulse", 32'(write_ovf), 32'd0);

        // Leave and re-enter an active state mid-read.
        step(2'b00, 2'd1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(2'b00, 2'd1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(2'b00, 2'd1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("t4_pre", 32'(data_out), 32'h22);
        step(2'b11, 2'd1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("t4_idle_dout", 32'(data_out), 32'd0);
        check_eq("t4_idle_ordy", 32'(output_ready), 32'd0);
        step(2'b10, 2'd1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("t4_restart", 32'(data_out), 32'h11);

        // Write beats read in the same cycle; rewind beats read.
        step(2'b00, 2'd1, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0);
        check_eq("t5_wr_ordy", 32'(output_ready), 32'd0);
        check_eq("t5_wr_len", 32'(duration), 32'd4);
        step(2'b00, 2'd1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        check_eq("t5_rst_ordy", 32'(output_ready), 32'd0);
        check_eq("t5_rst_eot", 32'(end_of_track), 32'd0);

`ifdef LOOP_PLAY_EN
        // Track 1 holds 0x11,0x22,0x33 followed by 0x44 here; shorten it to three words first.
        step(2'b00, 2'd1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(2'b00, 2'd1, 1'b1, 1'b0, words[i], 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(2'b00, 2'd1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            check_eq("t6_loop", 32'(data_out), 32'(words[i % 3]));
        end
`endif

        // Reset in the middle of a pending read.
        current_state = 2'b00; track_sel = 2'd1; read_en = 1'b1; read_rst = 1'b0; write_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_ordy", 32'(output_ready), 32'd0);
        check_eq("mid_rst_dout", 32'(data_out), 32'd0);
        check_eq("mid_rst_dur", 32'(duration), 32'd0);
        @(posedge clk);
        #1;
        check_eq("mid_rst_ordy2", 32'(output_ready), 32'd0);
        #2;
        rst_n = 1'b1;
        model_reset();

        // Random traffic.
        cur_trk = 2'd0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) cur_trk = 2'($urandom_range(0, NT - 1));
            st = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            step(st, cur_trk, ($urandom_range(0, 9) < 3), ($urandom_range(0, 99) < 3),
                 8'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
